// File: rtl/jtkcpu_memopnd_pkg.sv
// Shared definitions for the byte-wide memory operand sequencer.
//   MO_BW       : width of one CPU bus byte
//   mo_state_e  : sequencer states (idle, high byte, low byte, finish)
package jtkcpu_memopnd_pkg;

    localparam int MO_BW = 8;

    typedef enum logic [1:0] {
        MO_IDLE = 2'd0,
        MO_HI   = 2'd1,
        MO_LO   = 2'd2,
        MO_FIN  = 2'd3
    } mo_state_e;

endpackage

// File: rtl/jtkcpu_memopnd.sv
// Memory operand sequencer sitting between the ALU and the 8-bit CPU bus.
// Reads one or two bytes (big-endian, high byte at the lower address) and
// presents them as a 16-bit operand, or writes the ALU result back as one or
// two bytes. Driven by the control unit through a start/done handshake.
//
// Ports:
//   clk, rst (sync, active-low), cen (clock enable)
//   start, wr, len16, ea, wdata : transfer request, latched when accepted in idle
//   opnd                        : assembled read operand (8-bit reads zero-extend)
//   busy, done                  : busy from accepted start until done; done is a
//                                 one-cen-cycle pulse
//   bus_addr, bus_rd, bus_wr, bus_dout, bus_din, bus_ok : byte bus; a byte
//                                 completes on a cen cycle with strobe and bus_ok high
module jtkcpu_memopnd
    import jtkcpu_memopnd_pkg::*;
#(
    parameter int AW = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cen,
    input  logic               start,
    input  logic               wr,
    input  logic               len16,
    input  logic [AW-1:0]      ea,
    input  logic [15:0]        wdata,
    output logic [15:0]        opnd,
    output logic               busy,
    output logic               done,
    output logic [AW-1:0]      bus_addr,
    output logic               bus_rd,
    output logic               bus_wr,
    output logic [MO_BW-1:0]   bus_dout,
    input  logic [MO_BW-1:0]   bus_din,
    input  logic               bus_ok
);

    mo_state_e          state_q, state_d;
    logic               wr_q, wr_d;
    logic               len16_q, len16_d;
    logic [AW-1:0]      ea_q, ea_d;
    logic [15:0]        wdata_q, wdata_d;
    logic [15:0]        opnd_q, opnd_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [AW-1:0]      bus_addr_q, bus_addr_d;
    logic               bus_rd_q, bus_rd_d;
    logic               bus_wr_q, bus_wr_d;
    logic [MO_BW-1:0]   bus_dout_q, bus_dout_d;

    // Second byte lives at ea+1; the AW-bit add wraps the top of memory to 0.
    logic [AW-1:0]      ea_inc_s;
    assign ea_inc_s = ea_q + {{(AW-1){1'b0}}, 1'b1};

    // State and datapath registers; reset wins over cen and aborts any transfer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= MO_IDLE;
            wr_q       <= 1'b0;
            len16_q    <= 1'b0;
            ea_q       <= {AW{1'b0}};
            wdata_q    <= 16'h0000;
            opnd_q     <= 16'h0000;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bus_addr_q <= {AW{1'b0}};
            bus_rd_q   <= 1'b0;
            bus_wr_q   <= 1'b0;
            bus_dout_q <= {MO_BW{1'b0}};
        end else begin
            state_q    <= state_d;
            wr_q       <= wr_d;
            len16_q    <= len16_d;
            ea_q       <= ea_d;
            wdata_q    <= wdata_d;
            opnd_q     <= opnd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bus_addr_q <= bus_addr_d;
            bus_rd_q   <= bus_rd_d;
            bus_wr_q   <= bus_wr_d;
            bus_dout_q <= bus_dout_d;
        end
    end

    // Next-state logic: strobes are always active in HI/LO, so bus_ok alone
    // decides whether the current byte completes.
    always_comb begin
        state_d = state_q;
        if (cen) begin
            case (state_q)
                MO_IDLE: begin
                    if (start) begin
                        state_d = len16 ? MO_HI : MO_LO;
                    end else begin
                        state_d = MO_IDLE;
                    end
                end
                MO_HI: begin
                    if (bus_ok) begin
                        state_d = MO_LO;
                    end else begin
                        state_d = MO_HI;
                    end
                end
                MO_LO: begin
                    if (bus_ok) begin
                        state_d = MO_FIN;
                    end else begin
                        state_d = MO_LO;
                    end
                end
                MO_FIN: begin
                    state_d = MO_IDLE;
                end
                default: begin
                    state_d = MO_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Output and datapath logic: outputs are registered, so the values for
    // the next state are prepared on the transition into it.
    always_comb begin
        wr_d       = wr_q;
        len16_d    = len16_q;
        ea_d       = ea_q;
        wdata_d    = wdata_q;
        opnd_d     = opnd_q;
        busy_d     = busy_q;
        done_d     = done_q;
        bus_addr_d = bus_addr_q;
        bus_rd_d   = bus_rd_q;
        bus_wr_d   = bus_wr_q;
        bus_dout_d = bus_dout_q;
        if (cen) begin
            case (state_q)
                MO_IDLE: begin
                    done_d = 1'b0;
                    if (start) begin
                        wr_d       = wr;
                        len16_d    = len16;
                        ea_d       = ea;
                        wdata_d    = wdata;
                        busy_d     = 1'b1;
                        bus_addr_d = ea;
                        bus_rd_d   = ~wr;
                        bus_wr_d   = wr;
                        // Reads keep the data bus quiet; writes lead with the
                        // high byte for a 16-bit transfer.
                        if (!wr) begin
                            bus_dout_d = {MO_BW{1'b0}};
                        end else if (len16) begin
                            bus_dout_d = wdata[15:8];
                        end else begin
                            bus_dout_d = wdata[7:0];
                        end
                    end else begin
                        busy_d = 1'b0;
                    end
                end
                MO_HI: begin
                    if (bus_ok) begin
                        if (!wr_q) begin
                            opnd_d[15:8] = bus_din;
                        end else begin
                            opnd_d = opnd_q;
                        end
                        bus_addr_d = ea_inc_s;
                        bus_dout_d = wr_q ? wdata_q[7:0] : {MO_BW{1'b0}};
                    end else begin
                        bus_addr_d = bus_addr_q;
                    end
                end
                MO_LO: begin
                    if (bus_ok) begin
                        if (!wr_q) begin
                            opnd_d[7:0] = bus_din;
                            // 8-bit reads zero-extend; 16-bit reads keep the
                            // high byte captured in HI.
                            if (!len16_q) begin
                                opnd_d[15:8] = 8'h00;
                            end else begin
                                opnd_d[15:8] = opnd_q[15:8];
                            end
                        end else begin
                            opnd_d = opnd_q;
                        end
                        bus_rd_d   = 1'b0;
                        bus_wr_d   = 1'b0;
                        bus_dout_d = {MO_BW{1'b0}};
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                    end else begin
                        done_d = 1'b0;
                    end
                end
                MO_FIN: begin
                    done_d = 1'b0;
                end
                default: begin
                    done_d   = 1'b0;
                    busy_d   = 1'b0;
                    bus_rd_d = 1'b0;
                    bus_wr_d = 1'b0;
                end
            endcase
        end else begin
            done_d = done_q;
        end
    end

    assign opnd     = opnd_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign bus_addr = bus_addr_q;
    assign bus_rd   = bus_rd_q;
    assign bus_wr   = bus_wr_q;
    assign bus_dout = bus_dout_q;

endmodule

// File: tb/tb_jtkcpu_memopnd.sv
// Scoreboard bench for jtkcpu_memopnd: a byte-array memory answers the bus,
// the driver pushes expected bus bytes and operand results when it issues a
// transfer, and a monitor pops and compares as the DUT completes bytes/done.
module tb_jtkcpu_memopnd;
    localparam int AW = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           cen = 1'b0;
    logic           start = 1'b0;
    logic           wr = 1'b0;
    logic           len16 = 1'b0;
    logic [AW-1:0]  ea = 16'h0000;
    logic [15:0]    wdata = 16'h0000;
    logic           bus_ok = 1'b0;
    logic [15:0]    opnd;
    logic           busy, done;
    logic [AW-1:0]  bus_addr;
    logic           bus_rd, bus_wr;
    logic [7:0]     bus_dout, bus_din;

    logic [7:0]     mem [0:65535];
    assign bus_din = mem[bus_addr];

    always #5 clk = ~clk;

    jtkcpu_memopnd #(.AW(AW)) dut (
        .clk(clk), .rst(rst), .cen(cen), .start(start), .wr(wr), .len16(len16),
        .ea(ea), .wdata(wdata), .opnd(opnd), .busy(busy), .done(done),
        .bus_addr(bus_addr), .bus_rd(bus_rd), .bus_wr(bus_wr),
        .bus_dout(bus_dout), .bus_din(bus_din), .bus_ok(bus_ok)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          wr;
        logic [7:0]    data;
    } byte_op_t;

    byte_op_t    exp_ops[$];
    logic [15:0] exp_opnd[$];
    int total = 0;
    int bad = 0;
    int done_seen = 0;
    int rd_cycles = 0;
    logic [15:0] model_opnd = 16'h0000;
    logic rnd_en = 1'b0;
    logic force_cen = 1'b0;
    logic manual = 1'b0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endfunction

    // cen / bus_ok generator: steady, random, or left to the driver (manual)
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (!manual) begin
                if (force_cen) cen = 1'b1;
                else if (rnd_en) cen = ($urandom_range(0, 3) != 0);
                else cen = 1'b1;
                if (rnd_en) bus_ok = ($urandom_range(0, 2) != 0);
                else bus_ok = 1'b1;
            end
        end
    end

    // Monitor: bus bytes, wait-state stability, done events
    logic           p_hold = 1'b0;
    logic [AW-1:0]  p_addr = 16'h0000;
    logic           p_rd = 1'b0, p_wr = 1'b0, p_done = 1'b0, p_cen = 1'b0;
    logic [7:0]     p_dout = 8'h00;
    initial begin
        byte_op_t op;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (p_hold) begin
                    check("hold_addr", bus_addr, p_addr);
                    check("hold_strobe", {bus_rd, bus_wr}, {p_rd, p_wr});
                    check("hold_dout", bus_dout, p_dout);
                end
                if (p_done && !p_cen) check("done_held", done, 1'b1);
                if (bus_rd || bus_wr) begin
                    check("strobe_excl", bus_rd & bus_wr, 1'b0);
                    if (bus_rd && cen) rd_cycles++;
                    if (cen && bus_ok) begin
                        if (exp_ops.size() == 0) begin
                            total++; bad++;
                            $display("FAIL unexpected_byte actual_addr=%h wr=%b required=none", bus_addr, bus_wr);
                        end else begin
                            op = exp_ops.pop_front();
                            check("byte_addr", bus_addr, op.addr);
                            check("byte_dir", bus_wr, op.wr);
                            if (op.wr) begin
                                check("byte_wdata", bus_dout, op.data);
                                mem[bus_addr] = bus_dout;
                            end
                        end
                    end
                end
                if (done && cen) begin
                    done_seen++;
                    check("done_strobes", {bus_rd, bus_wr}, 2'b00);
                    check("done_busy", busy, 1'b0);
                    if (exp_opnd.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_done actual_opnd=%h required=none", opnd);
                    end else begin
                        check("opnd", opnd, exp_opnd.pop_front());
                    end
                end
                p_hold = (bus_rd || bus_wr) && !(cen && bus_ok);
                p_addr = bus_addr; p_rd = bus_rd; p_wr = bus_wr; p_dout = bus_dout;
                p_done = done; p_cen = cen;
            end else begin
                p_hold = 1'b0;
                p_done = 1'b0;
            end
        end
    end

    // Issue one request and push what the bus and opnd must show for it
    task automatic issue(input logic w, input logic l, input logic [AW-1:0] a, input logic [15:0] d);
        byte_op_t op;
        logic [AW-1:0] a1;
        a1 = a + 16'd1;
        @(posedge clk); #1;
        force_cen = 1'b1; cen = 1'b1;
        start = 1'b1; wr = w; len16 = l; ea = a; wdata = d;
        if (l) begin
            op.addr = a;  op.wr = w; op.data = w ? d[15:8] : 8'h00; exp_ops.push_back(op);
            op.addr = a1; op.wr = w; op.data = w ? d[7:0]  : 8'h00; exp_ops.push_back(op);
            if (!w) model_opnd = {mem[a], mem[a1]};
        end else begin
            op.addr = a;  op.wr = w; op.data = w ? d[7:0]  : 8'h00; exp_ops.push_back(op);
            if (!w) model_opnd = {8'h00, mem[a]};
        end
        exp_opnd.push_back(model_opnd);
        @(posedge clk); #1;
        start = 1'b0; force_cen = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_seen < target && n < 400) begin
            @(posedge clk);
            n++;
        end
        check("done_arrived", (done_seen >= target), 1'b1);
    endtask

    task automatic check_zero(string tag);
        check({tag, "_opnd"}, opnd, 16'h0000);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_rdwr"}, {bus_rd, bus_wr}, 2'b00);
        check({tag, "_addr"}, bus_addr, 16'h0000);
        check({tag, "_dout"}, bus_dout, 8'h00);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int r0;
        logic w, l;
        logic [AW-1:0] a;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom_range(0, 255));

        // reset state
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b1;

        // 16-bit read at 0x1234, latency 3 cycles from start
        mem[16'h1234] = 8'hAB; mem[16'h1235] = 8'hCD;
        d0 = done_seen;
        issue(1'b0, 1'b1, 16'h1234, 16'h0000);
        check("rd16_busy", busy, 1'b1);
        check("rd16_addr_hi", bus_addr, 16'h1234);
        check("rd16_done_c1", done, 1'b0);
        @(posedge clk); #1;
        check("rd16_addr_lo", bus_addr, 16'h1235);
        check("rd16_done_c2", done, 1'b0);
        @(posedge clk); #1;
        check("rd16_done_c3", done, 1'b1);
        check("rd16_busy_low", busy, 1'b0);
        check("rd16_opnd", opnd, 16'hABCD);
        wait_done(d0 + 1);

        // 8-bit read zero-extends over a previous 0xFFFF
        mem[16'h2000] = 8'hFF; mem[16'h2001] = 8'hFF;
        d0 = done_seen;
        issue(1'b0, 1'b1, 16'h2000, 16'h0000);
        wait_done(d0 + 1);
        mem[16'h0040] = 8'h9F;
        r0 = rd_cycles;
        d0 = done_seen;
        issue(1'b0, 1'b0, 16'h0040, 16'h1357);
        check("rd8_done_c1", done, 1'b0);
        @(posedge clk); #1;
        check("rd8_done_c2", done, 1'b1);
        check("rd8_opnd", opnd, 16'h009F);
        wait_done(d0 + 1);
        check("rd8_one_strobe", rd_cycles - r0, 1);

        // 16-bit write wrapping from 0xFFFF to 0x0000
        d0 = done_seen;
        issue(1'b1, 1'b1, 16'hFFFF, 16'h5AA5);
        wait_done(d0 + 1);
        check("wr_wrap_hi", mem[16'hFFFF], 8'h5A);
        check("wr_wrap_lo", mem[16'h0000], 8'hA5);
        check("wr_opnd_kept", opnd, 16'h009F);

        // wait states on the high byte with cen toggling
        mem[16'h3000] = 8'h12; mem[16'h3001] = 8'h34;
        manual = 1'b1;
        bus_ok = 1'b0;
        d0 = done_seen;
        issue(1'b0, 1'b1, 16'h3000, 16'h0000);
        for (int i = 0; i < 16; i++) begin
            cen = (i % 2 == 0);
            bus_ok = (i >= 3);
            if (i <= 4) begin
                check("wait_addr", bus_addr, 16'h3000);
                check("wait_rd", bus_rd, 1'b1);
            end
            @(posedge clk); #1;
        end
        manual = 1'b0;
        wait_done(d0 + 1);
        check("wait_opnd", opnd, 16'h1234);

        // reset in LO aborts without done; next start works
        mem[16'h4000] = 8'h11; mem[16'h4001] = 8'h22;
        issue(1'b0, 1'b1, 16'h4000, 16'h0000);
        @(posedge clk); #1;
        check("abort_rd", bus_rd, 1'b1);
        check("abort_addr", bus_addr, 16'h4001);
        d0 = done_seen;
        rst = 1'b0;
        @(posedge clk); #1;
        check_zero("abort");
        exp_ops.delete();
        exp_opnd.delete();
        model_opnd = 16'h0000;
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("abort_no_done", done_seen, d0);
        issue(1'b0, 1'b0, 16'h4001, 16'h0000);
        wait_done(d0 + 1);

        // start while busy and during FIN are ignored
        d0 = done_seen;
        issue(1'b1, 1'b1, 16'h5000, 16'hBEEF);
        start = 1'b1; wr = 1'b0; len16 = 1'b0; ea = 16'h6000;
        @(posedge clk); #1;
        start = 1'b0;
        begin
            int n;
            n = 0;
            while (!done && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
        end
        check("fin_reached", done, 1'b1);
        start = 1'b1; ea = 16'h7000;
        @(posedge clk); #1;
        start = 1'b0;
        check("fin_start_busy", busy, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("ign_busy", busy, 1'b0);
        check("ign_one_done", done_seen, d0 + 1);
        check("ign_mem_hi", mem[16'h5000], 8'hBE);
        check("ign_mem_lo", mem[16'h5001], 8'hEF);

        // randomized transfers with random cen and wait states
        rnd_en = 1'b1;
        for (int k = 0; k < 60; k++) begin
            w = 1'($urandom_range(0, 1));
            l = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            d0 = done_seen;
            issue(w, l, a, 16'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                start = 1'b1; ea = ~a; wr = ~w;
                @(posedge clk); #1;
                start = 1'b0;
            end
            wait_done(d0 + 1);
        end
        rnd_en = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("sb_empty", exp_ops.size() + exp_opnd.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
